// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and coordinate helpers shared by
// the sync generator and downstream display stages.
package vga_timing_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned H_DISPLAY_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   localparam int unsigned V_DISPLAY_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;
   localparam int unsigned V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef logic [COORD_W-1:0] coord_t;

   // Modulo-total increment for a scan counter.
   function automatic coord_t coord_inc(input coord_t value, input int unsigned total);
      return (value == COORD_W'(total - 1)) ? '0 : value + 1'b1;
   endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel clock-enable generator: free-running 0..CLK_DIV-1 divider with a
// registered one-clock tick while the divider reads CLK_DIV-1.
module pixel_tick_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic p_tick
);

   localparam int unsigned       DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   assign div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q  <= '0;
         p_tick <= 1'b0;
      end else begin
         div_q  <= div_d;
         p_tick <= (div_d == DIV_LAST);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters, sync/active decode and frame marker. Optional frame
// counter output is built when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               video_on_o,
   output logic               p_tick_o,
   output logic [COORD_W-1:0] pix_x_o,
   output logic [COORD_W-1:0] pix_y_o,
   output logic               frame_start_o
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,
   output logic [7:0]         frame_cnt_o
`endif
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST     = COORD_W'(H_TOTAL - 1);
   localparam coord_t V_LAST     = COORD_W'(V_TOTAL - 1);
   localparam coord_t H_ACT_END  = COORD_W'(H_DISPLAY);
   localparam coord_t V_ACT_END  = COORD_W'(V_DISPLAY);
   localparam coord_t H_SYNC_BEG = COORD_W'(H_DISPLAY + H_FRONT);
   localparam coord_t H_SYNC_END = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam coord_t V_SYNC_BEG = COORD_W'(V_DISPLAY + V_FRONT);
   localparam coord_t V_SYNC_END = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic   p_tick;
   coord_t x_next;
   coord_t y_next;
   logic   frame_wrap;

   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .p_tick (p_tick)
   );

   assign p_tick_o = p_tick;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      x_next = pix_x_o;
      y_next = pix_y_o;
      if (p_tick) begin
         x_next = coord_inc(pix_x_o, H_TOTAL);
         if (pix_x_o == H_LAST) begin
            y_next = coord_inc(pix_y_o, V_TOTAL);
         end
      end
   end

   assign frame_wrap = p_tick && (pix_x_o == H_LAST) && (pix_y_o == V_LAST);

   // Decoding from x_next/y_next keeps syncs aligned with the coordinates.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pix_x_o       <= '0;
         pix_y_o       <= '0;
         hsync_o       <= 1'b1;
         vsync_o       <= 1'b1;
         video_on_o    <= 1'b0;
         frame_start_o <= 1'b0;
      end else begin
         pix_x_o       <= x_next;
         pix_y_o       <= y_next;
         hsync_o       <= !((x_next >= H_SYNC_BEG) && (x_next <= H_SYNC_END));
         vsync_o       <= !((y_next >= V_SYNC_BEG) && (y_next <= V_SYNC_END));
         video_on_o    <= (x_next < H_ACT_END) && (y_next < V_ACT_END);
         frame_start_o <= frame_wrap;
      end
   end

`ifdef VGA_SYNC_FRAME_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_o <= '0;
      end else if (frame_wrap) begin
         frame_cnt_o <= frame_cnt_o + 1'b1;
      end
   end
`endif

endmodule
